// File: rtl/mc_ctrl_pkg.sv
// Purpose: shared encodings for the multicycle ARM-subset control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // ALU commands (cmd field of a DP instruction)
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_CMP = 4'b1010;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    // Instruction classes
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Result mux selects
    localparam logic [1:0] RS_ALUOUT = 2'b00;
    localparam logic [1:0] RS_DATA   = 2'b01;
    localparam logic [1:0] RS_ALURES = 2'b10;
    localparam logic [1:0] RS_PC     = 2'b11;

    // ALU operand selects
    localparam logic [1:0] SA_RD1  = 2'b00;
    localparam logic [1:0] SA_PC   = 2'b01;
    localparam logic [1:0] SB_RD2  = 2'b00;
    localparam logic [1:0] SB_IMM  = 2'b01;
    localparam logic [1:0] SB_FOUR = 2'b10;

    // Immediate formats
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    // TST/TEQ/CMP/CMN: flags-only commands, cmd = 10xx
    function automatic logic is_flag_cmd(input logic [3:0] cmd);
        return cmd[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/mc_cond_unit.sv
// Purpose: NZCV flags register and condition-code evaluation against the stored flags.
// Latency: flags load one edge after flag_load; cond_ex is combinational from nzcv/cond.
// Backpressure: none.
// Ports: clk, reset_n (sync, active low), cond, alu_flags, flag_load -> nzcv, cond_ex.
// Build option FULL_COND_EN: decode all 15 conditions; otherwise only EQ/NE/AL execute.
module mc_cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_load,
    output logic [3:0] nzcv,
    output logic       cond_ex
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nzcv <= 4'b0000;
        end else if (flag_load) begin
            nzcv <= alu_flags;
        end
    end

    // nzcv bit order: [3]=N [2]=Z [1]=C [0]=V
    always_comb begin
        cond_ex = 1'b0;
`ifdef FULL_COND_EN
        case (cond)
            COND_EQ: cond_ex = nzcv[2];
            COND_NE: cond_ex = !nzcv[2];
            COND_CS: cond_ex = nzcv[1];
            COND_CC: cond_ex = !nzcv[1];
            COND_MI: cond_ex = nzcv[3];
            COND_PL: cond_ex = !nzcv[3];
            COND_VS: cond_ex = nzcv[0];
            COND_VC: cond_ex = !nzcv[0];
            COND_HI: cond_ex = nzcv[1] && !nzcv[2];
            COND_LS: cond_ex = !nzcv[1] || nzcv[2];
            COND_GE: cond_ex = (nzcv[3] == nzcv[0]);
            COND_LT: cond_ex = (nzcv[3] != nzcv[0]);
            COND_GT: cond_ex = !nzcv[2] && (nzcv[3] == nzcv[0]);
            COND_LE: cond_ex = nzcv[2] || (nzcv[3] != nzcv[0]);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
`else
        case (cond)
            COND_EQ: cond_ex = nzcv[2];
            COND_NE: cond_ex = !nzcv[2];
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
`endif
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Purpose: multicycle control unit - Moore main FSM, memory wait counter, NZCV flags.
// Latency: FETCH/MEMRD/MEMWR last MEM_LAT cycles, every other state one cycle.
// Backpressure: none; fixed memory latency is absorbed by the internal wait counter.
// Ports: clk, reset_n (sync, active low); instruction fields cond/op/funct/rd and
//        alu_flags in; datapath enables/selects, alu_control, nzcv, state_o out.
// Build option FULL_COND_EN (in mc_cond_unit) widens the condition decode.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         cond,
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    input  logic [3:0]         rd,
    input  logic [3:0]         alu_flags,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         imm_src,
    output logic [1:0]         reg_src,
    output logic [ALUOP_W-1:0] alu_control,
    output logic [3:0]         nzcv,
    output logic [3:0]         state_o
);

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic       mem_state;
    logic       mem_done;
    logic       cond_ex;
    logic       flag_load;
    logic       pc_w;
    logic       ir_w;
    logic       reg_w;
    logic       mem_w;

    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign mem_done  = (wait_cnt == LAST_WAIT);

    // S bit set, or a flags-only compare, latches the ALU flags as EXEC completes
    assign flag_load = ((state == S_EXECR) || (state == S_EXECI)) &&
                       (funct[0] || is_flag_cmd(funct[4:1]));

    mc_cond_unit u_cond (
        .clk       (clk),
        .reset_n   (reset_n),
        .cond      (cond),
        .alu_flags (alu_flags),
        .flag_load (flag_load),
        .nzcv      (nzcv),
        .cond_ex   (cond_ex)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_FETCH;
            wait_cnt <= 4'd0;
        end else begin
            state <= next_state;
            if (mem_state && !mem_done) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
        end
    end

    always_comb begin
        next_state  = S_FETCH;
        pc_w        = 1'b0;
        ir_w        = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        adr_src     = 1'b0;
        result_src  = RS_ALUOUT;
        alu_src_a   = SA_RD1;
        alu_src_b   = SB_RD2;
        imm_src     = IMM_DP;
        alu_control = '0;
        case (state)
            S_FETCH: begin
                alu_src_a   = SA_PC;
                alu_src_b   = SB_FOUR;
                alu_control = ALUOP_W'(ALU_ADD);
                result_src  = RS_ALURES;
                if (mem_done) begin
                    ir_w       = 1'b1;
                    pc_w       = 1'b1;
                    next_state = S_DECODE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a   = SA_PC;
                alu_src_b   = SB_FOUR;
                alu_control = ALUOP_W'(ALU_ADD);
                result_src  = RS_ALURES;
                if (!cond_ex) begin
                    next_state = S_FETCH;
                end else begin
                    case (op)
                        OP_MEM:  next_state = S_MEMADR;
                        OP_DP:   next_state = funct[5] ? S_EXECI : S_EXECR;
                        OP_BR:   next_state = S_BRANCH;
                        default: next_state = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_b   = SB_IMM;
                imm_src     = IMM_MEM;
                // U bit picks the offset direction
                alu_control = funct[3] ? ALUOP_W'(ALU_ADD) : ALUOP_W'(ALU_SUB);
                next_state  = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src    = 1'b1;
                next_state = mem_done ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                result_src = RS_DATA;
                reg_w      = 1'b1;
                pc_w       = (rd == 4'd15);
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                adr_src    = 1'b1;
                mem_w      = 1'b1;
                next_state = mem_done ? S_FETCH : S_MEMWR;
            end
            S_EXECR: begin
                alu_control = ALUOP_W'(funct[4:1]);
                next_state  = S_ALUWB;
            end
            S_EXECI: begin
                alu_control = ALUOP_W'(funct[4:1]);
                alu_src_b   = SB_IMM;
                imm_src     = IMM_DP;
                next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RS_ALUOUT;
                reg_w      = !is_flag_cmd(funct[4:1]);
                pc_w       = !is_flag_cmd(funct[4:1]) && (rd == 4'd15);
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b   = SB_IMM;
                imm_src     = IMM_BR;
                alu_control = ALUOP_W'(ALU_ADD);
                pc_w        = 1'b1;
                // BL: link register takes the PC while the branch target goes to PC
                if (funct[4]) begin
                    reg_w      = 1'b1;
                    result_src = RS_PC;
                end else begin
                    result_src = RS_ALURES;
                end
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Enables are killed combinationally so a reset mid-instruction writes nothing
    assign pc_write  = pc_w  && reset_n;
    assign ir_write  = ir_w  && reset_n;
    assign reg_write = reg_w && reset_n;
    assign mem_write = mem_w && reset_n;

    // [1]: STR reads Rd as the second source; [0]: branches read PC as the first
    assign reg_src = {(op == OP_MEM) && !funct[0], (op == OP_BR)};

    assign state_o = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [3:0] nzcv;
        logic [3:0] state;
    } obs_t;

    typedef struct packed {
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [3:0] alu_control;
    } aux_t;

    typedef struct {
        int         sel;
        logic       rst_n;
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] flags;
        obs_t       exp;
        obs_t       mask;
    } vec_t;

    typedef struct {
        int   id;
        int   sel;
        obs_t exp;
        obs_t mask;
    } sb_t;

    typedef struct {
        int         id;
        logic [3:0] st;
        aux_t       aux;
    } hsb_t;

    localparam obs_t M_ALL = 15'h7FFF;
    localparam obs_t M_WE  = 15'h7800;

    localparam aux_t A_FETCH = 10'b01_10_00_0100;
    localparam aux_t A_ZERO  = 10'b00_00_00_0000;

    // Three instances share stimulus; each test targets the one with the latency it needs
    obs_t obs [3];
    aux_t aux [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pc_write, adr_src, mem_write, ir_write, reg_write;
        logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, reg_src;
        logic [3:0] alu_control, nzcv, state_o;

        mc_ctrl_fsm #(.MEM_LAT(g + 1), .ALUOP_W(4)) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .cond        (cond),
            .op          (op),
            .funct       (funct),
            .rd          (rd),
            .alu_flags   (alu_flags),
            .pc_write    (pc_write),
            .adr_src     (adr_src),
            .mem_write   (mem_write),
            .ir_write    (ir_write),
            .reg_write   (reg_write),
            .result_src  (result_src),
            .alu_src_a   (alu_src_a),
            .alu_src_b   (alu_src_b),
            .imm_src     (imm_src),
            .reg_src     (reg_src),
            .alu_control (alu_control),
            .nzcv        (nzcv),
            .state_o     (state_o)
        );

        assign obs[g] = {pc_write, ir_write, reg_write, mem_write, adr_src,
                         result_src, nzcv, state_o};
        assign aux[g] = {alu_src_a, alu_src_b, imm_src, alu_control};
    end

    vec_t tbl [$];
    sb_t  sb  [$];
    hsb_t hsb [$];

    int n_checks = 0;
    int n_err    = 0;
    int hid      = 0;

    int         cur_sel;
    logic [3:0] cur_cond;
    logic [1:0] cur_op;
    logic [5:0] cur_funct;
    logic [3:0] cur_rd;
    logic [3:0] cur_flags;

    task automatic ins(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] fl);
        cur_cond  = c;
        cur_op    = o;
        cur_funct = f;
        cur_rd    = r;
        cur_flags = fl;
    endtask

    // w = {pc_write, ir_write, reg_write, mem_write, adr_src}
    function automatic obs_t ex(input logic [3:0] st, input logic [4:0] w,
                                input logic [1:0] rs, input logic [3:0] nz);
        return {w, rs, nz, st};
    endfunction

    task automatic add_vec(input logic rst, input obs_t e, input obs_t m);
        vec_t v;
        v.sel   = cur_sel;
        v.rst_n = rst;
        v.cond  = cur_cond;
        v.op    = cur_op;
        v.funct = cur_funct;
        v.rd    = cur_rd;
        v.flags = cur_flags;
        v.exp   = e;
        v.mask  = m;
        tbl.push_back(v);
    endtask

    task automatic row(input obs_t e);
        add_vec(1'b1, e, M_ALL);
    endtask

    task automatic drive_cur(input logic rst);
        reset_n   = rst;
        cond      = cur_cond;
        op        = cur_op;
        funct     = cur_funct;
        rd        = cur_rd;
        alu_flags = cur_flags;
    endtask

    task automatic hstep(input logic [3:0] st, input aux_t a);
        hsb_t h;
        hsb_t got;
        @(negedge clk);
        drive_cur(1'b1);
        h.id  = hid;
        h.st  = st;
        h.aux = a;
        hsb.push_back(h);
        hid++;
        #1;
        got = hsb.pop_front();
        n_checks++;
        if ({obs[0].state, aux[0]} !== {got.st, got.aux}) begin
            n_err++;
            $display("FAIL hand%0d: state/aux got %h/%b expected %h/%b",
                     got.id, obs[0].state, aux[0], got.st, got.aux);
        end
    endtask

    initial begin
        sb_t e;
        obs_t act;

        // ---------------- vector table ----------------
        cur_sel = 0;
        ins(4'hE, 2'd0, 6'b001000, 4'd1, 4'hF);                 // ADD R1,R2,R3
        row(ex(4'd0, 5'b11000, 2'd2, 4'h0));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h0));
        row(ex(4'd6, 5'b00000, 2'd0, 4'h0));
        row(ex(4'd8, 5'b00100, 2'd0, 4'h0));
        ins(4'hE, 2'd0, 6'b010101, 4'd0, 4'h4);                 // CMP, Z from ALU
        row(ex(4'd0, 5'b11000, 2'd2, 4'h0));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h0));
        row(ex(4'd6, 5'b00000, 2'd0, 4'h0));
        row(ex(4'd8, 5'b00000, 2'd0, 4'h4));
        ins(4'h1, 2'd0, 6'b001000, 4'd1, 4'h0);                 // ADDNE, squashed
        row(ex(4'd0, 5'b11000, 2'd2, 4'h4));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h4));
        ins(4'hE, 2'd2, 6'b010000, 4'd0, 4'h0);                 // BL
        row(ex(4'd0, 5'b11000, 2'd2, 4'h4));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h4));
        row(ex(4'd9, 5'b10100, 2'd3, 4'h4));
        ins(4'hE, 2'd2, 6'b100000, 4'd0, 4'h0);                 // B
        row(ex(4'd0, 5'b11000, 2'd2, 4'h4));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h4));
        row(ex(4'd9, 5'b10000, 2'd2, 4'h4));
        ins(4'hE, 2'd0, 6'b111010, 4'd15, 4'h0);                // MOV PC,#imm
        row(ex(4'd0, 5'b11000, 2'd2, 4'h4));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h4));
        row(ex(4'd7, 5'b00000, 2'd0, 4'h4));
        row(ex(4'd8, 5'b10100, 2'd0, 4'h4));
        ins(4'hE, 2'd0, 6'b010001, 4'd15, 4'h6);                // TST with rd=15
        row(ex(4'd0, 5'b11000, 2'd2, 4'h4));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h4));
        row(ex(4'd6, 5'b00000, 2'd0, 4'h4));
        row(ex(4'd8, 5'b00000, 2'd0, 4'h6));
        ins(4'h0, 2'd0, 6'b001001, 4'd2, 4'h8);                 // ADDSEQ, loads N
        row(ex(4'd0, 5'b11000, 2'd2, 4'h6));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h6));
        row(ex(4'd6, 5'b00000, 2'd0, 4'h6));
        row(ex(4'd8, 5'b00100, 2'd0, 4'h8));
        ins(4'hE, 2'd3, 6'b000000, 4'd0, 4'h0);                 // op=11
        row(ex(4'd0, 5'b11000, 2'd2, 4'h8));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h8));
        ins(4'hB, 2'd0, 6'b001000, 4'd3, 4'h0);                 // ADDLT, N=1 V=0
        row(ex(4'd0, 5'b11000, 2'd2, 4'h8));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h8));
`ifdef FULL_COND_EN
        row(ex(4'd6, 5'b00000, 2'd0, 4'h8));
        row(ex(4'd8, 5'b00100, 2'd0, 4'h8));
        row(ex(4'd0, 5'b11000, 2'd2, 4'h8));
`else
        row(ex(4'd0, 5'b11000, 2'd2, 4'h8));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h8));
        row(ex(4'd0, 5'b11000, 2'd2, 4'h8));
`endif

        cur_sel = 2;                                            // MEM_LAT=3
        ins(4'hE, 2'd1, 6'b011001, 4'd4, 4'h0);                 // LDR
        add_vec(1'b0, ex(4'd0, 5'b00000, 2'd0, 4'h0), M_WE);
        row(ex(4'd0, 5'b00000, 2'd2, 4'h0));
        row(ex(4'd0, 5'b00000, 2'd2, 4'h0));
        row(ex(4'd0, 5'b11000, 2'd2, 4'h0));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h0));
        row(ex(4'd2, 5'b00000, 2'd0, 4'h0));
        row(ex(4'd3, 5'b00001, 2'd0, 4'h0));
        row(ex(4'd3, 5'b00001, 2'd0, 4'h0));
        row(ex(4'd3, 5'b00001, 2'd0, 4'h0));
        row(ex(4'd4, 5'b00100, 2'd1, 4'h0));
        row(ex(4'd0, 5'b00000, 2'd2, 4'h0));

        cur_sel = 1;                                            // MEM_LAT=2
        ins(4'hE, 2'd0, 6'b001001, 4'd2, 4'h6);                 // ADDS
        add_vec(1'b0, ex(4'd0, 5'b00000, 2'd0, 4'h0), M_WE);
        row(ex(4'd0, 5'b00000, 2'd2, 4'h0));
        row(ex(4'd0, 5'b11000, 2'd2, 4'h0));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h0));
        row(ex(4'd6, 5'b00000, 2'd0, 4'h0));
        row(ex(4'd8, 5'b00100, 2'd0, 4'h6));
        ins(4'hE, 2'd1, 6'b011000, 4'd4, 4'h0);                 // STR, reset in MEMWR
        row(ex(4'd0, 5'b00000, 2'd2, 4'h6));
        row(ex(4'd0, 5'b11000, 2'd2, 4'h6));
        row(ex(4'd1, 5'b00000, 2'd2, 4'h6));
        row(ex(4'd2, 5'b00000, 2'd0, 4'h6));
        row(ex(4'd5, 5'b00011, 2'd0, 4'h6));
        add_vec(1'b0, ex(4'd5, 5'b00001, 2'd0, 4'h6), M_ALL);
        row(ex(4'd0, 5'b00000, 2'd2, 4'h0));
        row(ex(4'd0, 5'b11000, 2'd2, 4'h0));

        // ---------------- run ----------------
        reset_n   = 1'b0;
        cond      = 4'h0;
        op        = 2'd0;
        funct     = 6'd0;
        rd        = 4'd0;
        alu_flags = 4'h0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            sb_t s;
            @(negedge clk);
            reset_n   = tbl[i].rst_n;
            cond      = tbl[i].cond;
            op        = tbl[i].op;
            funct     = tbl[i].funct;
            rd        = tbl[i].rd;
            alu_flags = tbl[i].flags;
            s.id   = i;
            s.sel  = tbl[i].sel;
            s.exp  = tbl[i].exp;
            s.mask = tbl[i].mask;
            sb.push_back(s);
            #1;
            e   = sb.pop_front();
            act = obs[e.sel];
            n_checks++;
            if ((act & e.mask) !== (e.exp & e.mask)) begin
                n_err++;
                $display("FAIL vec%0d dut%0d: got %h expected %h (mask %h)",
                         e.id, e.sel, act, e.exp, e.mask);
            end
        end

        // ---------------- hand sequences: operand/ALU selects ----------------
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        cur_sel = 0;
        ins(4'hE, 2'd1, 6'b010000, 4'd5, 4'h0);                 // STR, U=0
        hstep(4'd0, A_FETCH);
        hstep(4'd1, A_FETCH);
        hstep(4'd2, 10'b00_01_01_0010);
        hstep(4'd5, A_ZERO);
        ins(4'hE, 2'd1, 6'b011001, 4'd4, 4'h0);                 // LDR, U=1
        hstep(4'd0, A_FETCH);
        hstep(4'd1, A_FETCH);
        hstep(4'd2, 10'b00_01_01_0100);
        hstep(4'd3, A_ZERO);
        hstep(4'd4, A_ZERO);
        ins(4'hE, 2'd0, 6'b101000, 4'd1, 4'h0);                 // ADD imm
        hstep(4'd0, A_FETCH);
        hstep(4'd1, A_FETCH);
        hstep(4'd7, 10'b00_01_00_0100);
        hstep(4'd8, A_ZERO);
        ins(4'hE, 2'd0, 6'b011000, 4'd1, 4'h0);                 // ORR reg
        hstep(4'd0, A_FETCH);
        hstep(4'd1, A_FETCH);
        hstep(4'd6, 10'b00_00_00_1100);
        hstep(4'd8, A_ZERO);
        ins(4'hE, 2'd2, 6'b000000, 4'd0, 4'h0);                 // B
        hstep(4'd0, A_FETCH);
        hstep(4'd1, A_FETCH);
        hstep(4'd9, 10'b00_01_10_0100);
        hstep(4'd0, A_FETCH);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control unit for the ARM-subset core: replaces the single-cycle decoder/conditional-logic pair with a Moore main FSM, a registered NZCV flags register and a memory wait-state counter.
- Sits between the instruction register fields / ALU flags and the shared-bus datapath.
- Generalised over memory latency and ALU-op width.
- Evaluates full condition codes against the stored flags.

Parameters:
- MEM_LAT, 1, cycles each memory state (FETCH, MEMRD, MEMWR) is held; legal range 1..15.
- ALUOP_W, 4, width of the ALUControl output; funct[4:1] is zero-extended when ALUOP_W > 4.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cond  in  4  instruction condition field.
- op  in  2  instruction class: 00 DP, 01 LDR/STR, 10 B/BL.
- funct  in  6  I bit, cmd[3:0] (or P/U/B/W for memory ops), S/L bit.
- rd  in  4  destination register; 15 means the write targets the PC.
- alu_flags  in  4  combinational NZCV from the ALU.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult, 11 PC.
- alu_src_a  out  2  ALU A input: 00 RD1, 01 PC.
- alu_src_b  out  2  ALU B input: 00 RD2, 01 ExtImm, 10 constant 4.
- imm_src  out  2  immediate format: 00 DP, 01 memory, 10 branch.
- reg_src  out  2  register-address steering, same meaning as the single-cycle decoder.
- alu_control  out  ALUOP_W  ALU operation.
- nzcv  out  4  registered flags.
- state_o  out  4  current state, for debug.

Behaviour:
- States (4-bit encoding):
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
  - Unused encodings go to FETCH on the next edge.
- Reset: while reset_n=0 at a clock edge, state becomes FETCH, wait counter 0 and nzcv 0000. Every write enable (pc_write, ir_write, reg_write, mem_write) is forced to 0 combinationally while reset_n=0. Reset mid-instruction abandons it with no write.
- Wait counter: in FETCH, MEMRD and MEMWR the state is held until the counter reaches MEM_LAT-1, then the counter clears and the state advances.
  - In FETCH, ir_write and pc_write pulse only in the final cycle.
  - In MEMWR, mem_write is high for all MEM_LAT cycles.
  - With MEM_LAT=1 there is no stall.
- Transitions:
  - FETCH→DECODE.
  - DECODE→FETCH if condEx=0 (instruction squashed, no writes).
  - Otherwise from DECODE by op: 01→MEMADR; 00 with I=1→EXECI; 00 with I=0→EXECR; 10→BRANCH; op=11→FETCH.
  - MEMADR→MEMRD if funct[0]=1, otherwise MEMWR.
  - MEMRD→MEMWB; MEMWB→FETCH; MEMWR→FETCH.
  - EXECR/EXECI→ALUWB; ALUWB→FETCH; BRANCH→FETCH.
- Per-state outputs; unlisted outputs are 0:
  - FETCH: adr_src=0, alu_src_a=01, alu_src_b=10, add, result_src=10.
  - DECODE: alu_src_a=01, alu_src_b=10, add, result_src=10.
  - MEMADR: alu_src_b=01, imm_src=01; add if funct[3]=1, else sub.
  - MEMRD/MEMWR: adr_src=1.
  - MEMWB: result_src=01, reg_write=1, pc_write=(rd==15).
  - EXECR/EXECI: alu_control=funct[4:1]; EXECI also alu_src_b=01, imm_src=00.
  - ALUWB: result_src=00; reg_write=1 unless cmd is 1000/1001/1010/1011 (TST/TEQ/CMP/CMN); pc_write=(rd==15 and reg_write).
  - BRANCH: alu_src_b=01, imm_src=10, add, result_src=10, pc_write=1; when funct[4]=1 (BL), reg_write=1 to R14 with result_src=11.
- Flags:
  - nzcv is loaded from alu_flags at the end of EXECR/EXECI when funct[0]=1.
  - Flag compare commands (cmd 1000..1011) always load flags.
  - condEx uses registered nzcv, never alu_flags, so an S-instruction never affects its own condition.

Optional Feature:
- Macro FULL_COND_EN.
- Defined: all 15 ARM conditions are decoded: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Cond 1111 gives condEx=0.
- Undefined: only EQ (0000), NE (0001) and AL (1110) are decoded; every other cond gives condEx=0 (squash).

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings;
  - ALU command constants: ADD=0100, SUB=0010, AND=0000, ORR=1100, MOV=1101, CMP=1010;
  - op and cond code constants;
  - the result_src, alu_src_a and alu_src_b select encodings.
- One sub-module, mc_cond_unit, contains the flags register plus condition evaluation, and owns the FULL_COND_EN switch.

Test Plan:
- ADD R1,R2,R3 with cond=1110, MEM_LAT=1:
  - states 0,1,6,8,0 over 4 cycles;
  - reg_write=1 only in ALUWB;
  - nzcv unchanged.
- LDR with funct=011001 and MEM_LAT=3:
  - FETCH held 3 cycles, ir_write high only in the 3rd;
  - MEMRD held 3 cycles;
  - MEMWB gives reg_write=1, result_src=01.
- CMP with alu_flags=0100, then ADDNE (cond=0001):
  - nzcv=0100 after EXECR;
  - ADDNE goes DECODE→FETCH with no reg_write.
- BL at cond=1110, funct[4]=1:
  - BRANCH gives pc_write=1, reg_write=1, result_src=11.
- reset_n=0 asserted during MEMWR with MEM_LAT=2:
  - mem_write drops to 0 the same cycle;
  - next state is FETCH, nzcv=0000.
- FULL_COND_EN set, nzcv=1000 (N=1, V=0), cond=1011 (LT): instruction executes.
- FULL_COND_EN undefined, same stimulus: instruction is squashed.
